// File: rtl/sha_msg_sched_if.sv
// Bundles the sha_msg_sched load request, message block and window outputs.
// Optional macro SHA_SCHED_WIN_IDX_EN adds the win_idx window-index signal.
interface sha_msg_sched_if #(
   parameter int DELAY  = 8,
   parameter int WORD_S = 32
);
   logic                      en;
   logic [16*WORD_S-1:0]      M;
   logic [DELAY*WORD_S-1:0]   W;
   logic                      en_next;
   logic                      busy;
`ifdef SHA_SCHED_WIN_IDX_EN
   logic [5:0]                win_idx;
`endif

   // Block source: issues load requests, consumes windows.
   modport master (
      output en,
      output M,
      input  W,
      input  en_next,
      input  busy
`ifdef SHA_SCHED_WIN_IDX_EN
      , input win_idx
`endif
   );

   // Schedule generator side.
   modport slave (
      input  en,
      input  M,
      output W,
      output en_next,
      output busy
`ifdef SHA_SCHED_WIN_IDX_EN
      , output win_idx
`endif
   );
endinterface

// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule generator: expands one 512-bit block into W[0..63],
// one word per clock, and releases the words in windows of DELAY words, each
// announced by a one-cycle en_next pulse.
// Optional macro SHA_SCHED_WIN_IDX_EN adds win_idx (first word index of W).
module sha_msg_sched #(
   parameter int DELAY  = 8,
   parameter int WORD_S = 32
) (
   input  logic           clk,
   input  logic           reset,
   sha_msg_sched_if.slave bus
);

   // Slot index of the last word in a window; DELAY is a power of two.
   localparam logic [5:0] SLOT_LAST = 6'(DELAY - 1);
   localparam logic [5:0] T_LAST    = 6'd63;
   localparam logic [5:0] T_MSG     = 6'd16;

   function automatic logic [WORD_S-1:0] rotr(input logic [WORD_S-1:0] x, input int n);
      return (x >> n) | (x << (WORD_S - n));
   endfunction

   function automatic logic [WORD_S-1:0] sig0(input logic [WORD_S-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_S-1:0] sig1(input logic [WORD_S-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // hist_q[0] is the oldest word (W[t-16] once expanding), hist_q[15] the newest.
   logic [WORD_S-1:0]       hist_q [16];
   logic [WORD_S-1:0]       hist_d [16];
   logic [WORD_S-1:0]       fill_q [DELAY];
   logic [WORD_S-1:0]       fill_d [DELAY];
   logic [DELAY*WORD_S-1:0] w_q, w_d;
   logic [5:0]              t_q, t_d;
   logic                    busy_q, busy_d;
   logic                    en_next_q, en_next_d;
   logic [WORD_S-1:0]       new_word;
   logic [5:0]              slot;
`ifdef SHA_SCHED_WIN_IDX_EN
   logic [5:0]              win_idx_q, win_idx_d;
`endif

   // Next-state: block load when idle, otherwise one schedule word per cycle.
   always_comb begin
      hist_d    = hist_q;
      fill_d    = fill_q;
      w_d       = w_q;
      t_d       = t_q;
      busy_d    = busy_q;
      en_next_d = 1'b0;
`ifdef SHA_SCHED_WIN_IDX_EN
      win_idx_d = win_idx_q;
`endif
      slot      = t_q & SLOT_LAST;
      // The first 16 words come straight out of the history (which then holds
      // them in order); later words use the expansion recurrence.
      if (t_q < T_MSG) begin
         new_word = hist_q[0];
      end else begin
         new_word = sig1(hist_q[14]) + hist_q[9] + sig0(hist_q[1]) + hist_q[0];
      end

      if (busy_q) begin
         for (int i = 0; i < 15; i++) begin
            hist_d[i] = hist_q[i+1];
         end
         hist_d[15] = new_word;

         for (int i = 0; i < DELAY; i++) begin
            if (slot == 6'(i)) begin
               fill_d[i] = new_word;
            end
         end

         // Window complete: publish the fill buffer including the word just made.
         if (slot == SLOT_LAST) begin
            for (int i = 0; i < DELAY; i++) begin
               w_d[i*WORD_S +: WORD_S] = fill_d[i];
            end
            en_next_d = 1'b1;
`ifdef SHA_SCHED_WIN_IDX_EN
            win_idx_d = t_q & ~SLOT_LAST;
`endif
         end

         // The counter parks at 63; only a new load brings it back to 0.
         if (t_q == T_LAST) begin
            busy_d = 1'b0;
         end else begin
            t_d = t_q + 6'd1;
         end
      end else if (bus.en) begin
         for (int i = 0; i < 16; i++) begin
            hist_d[i] = bus.M[(15-i)*WORD_S +: WORD_S];
         end
         t_d    = 6'd0;
         busy_d = 1'b1;
      end
   end

   // State registers; asynchronous reset aborts any block in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q    <= '{default: '0};
         fill_q    <= '{default: '0};
         w_q       <= '0;
         t_q       <= '0;
         busy_q    <= 1'b0;
         en_next_q <= 1'b0;
`ifdef SHA_SCHED_WIN_IDX_EN
         win_idx_q <= '0;
`endif
      end else begin
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         w_q       <= w_d;
         t_q       <= t_d;
         busy_q    <= busy_d;
         en_next_q <= en_next_d;
`ifdef SHA_SCHED_WIN_IDX_EN
         win_idx_q <= win_idx_d;
`endif
      end
   end

   assign bus.W       = w_q;
   assign bus.en_next = en_next_q;
   assign bus.busy    = busy_q;
`ifdef SHA_SCHED_WIN_IDX_EN
   assign bus.win_idx = win_idx_q;
`endif

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: reset state, "abc" block windows and
// timing, back-to-back blocks with en held high, and a mid-block reset.
module tb_sha_msg_sched;
   localparam int DELAY  = 8;
   localparam int WORD_S = 32;
   localparam int NWIN   = 64 / DELAY;

   typedef struct {
      int          blk;   // 0 = "abc" block, 1 = counting block (word i = i)
      int          widx;  // schedule word index
      logic [31:0] exp;   // hand-computed value
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   sha_msg_sched_if #(.DELAY(DELAY), .WORD_S(WORD_S)) bus();
   sha_msg_sched #(.DELAY(DELAY), .WORD_S(WORD_S)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int nchecks = 0;
   int nerrors = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Window capture ring: every en_next pulse records W, the cycle and win_idx.
   logic [31:0] cap     [16][DELAY];
   int          cap_cyc [16];
   logic [5:0]  cap_idx [16];
   int          npulse = 0;

   always @(negedge clk) begin
      if (bus.en_next === 1'b1) begin
         for (int i = 0; i < DELAY; i++) cap[npulse % 16][i] <= bus.W[i*WORD_S +: WORD_S];
         cap_cyc[npulse % 16] <= cyc;
`ifdef SHA_SCHED_WIN_IDX_EN
         cap_idx[npulse % 16] <= bus.win_idx;
`else
         cap_idx[npulse % 16] <= 6'd0;
`endif
         npulse <= npulse + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] t_rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ref_word(input logic [511:0] m, input int t);
      logic [31:0] w [64];
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = m[(15-i)*32 +: 32];
         else w[i] = (t_rotr(w[i-2], 17) ^ t_rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                   + (t_rotr(w[i-15], 7) ^ t_rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      end
      return w[t];
   endfunction

   function automatic logic [31:0] cap_word(input int base, input int blk, input int t);
      return cap[(base + blk*NWIN + t/DELAY) % 16][t % DELAY];
   endfunction

   // Drive a load; returns with the clock at the negedge after the load edge.
   task automatic do_load(input logic [511:0] m, output int l);
      @(negedge clk);
      bus.M  = m;
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      l = cyc;
   endtask

   // Compare one captured block: every word, pulse cycles and window indices.
   task automatic check_block(input string tag, input int base, input int blk,
                              input logic [511:0] m, input int l);
      for (int t = 0; t < 64; t++)
         chk($sformatf("%s_w%0d", tag, t), cap_word(base, blk, t), ref_word(m, t));
      for (int k = 0; k < NWIN; k++) begin
         chk($sformatf("%s_pulse_cyc%0d", tag, k), cap_cyc[(base + blk*NWIN + k) % 16],
             l + (k+1)*DELAY);
`ifdef SHA_SCHED_WIN_IDX_EN
         chk($sformatf("%s_win_idx%0d", tag, k), cap_idx[(base + blk*NWIN + k) % 16], k*DELAY);
`endif
      end
   endtask

   logic [511:0] m_abc;
   logic [511:0] m_cnt;
   vec_t         tbl [12];
   int           l0;
   int           base;
   logic         exp_pulse;

   initial begin
      m_abc = {32'h61626380, 448'h0, 32'h00000018};
      for (int i = 0; i < 16; i++) m_cnt[(15-i)*32 +: 32] = 32'(i);

      tbl[0]  = '{0, 0,  32'h61626380};
      tbl[1]  = '{0, 1,  32'h00000000};
      tbl[2]  = '{0, 15, 32'h00000018};
      tbl[3]  = '{0, 16, 32'h61626380};
      tbl[4]  = '{0, 17, 32'h000F0000};
      tbl[5]  = '{0, 18, 32'h7DA86405};
      tbl[6]  = '{0, 19, 32'h600003C6};
      tbl[7]  = '{1, 0,  32'h00000000};
      tbl[8]  = '{1, 5,  32'h00000005};
      tbl[9]  = '{1, 15, 32'h0000000F};
      tbl[10] = '{1, 16, 32'h02070009};
      tbl[11] = '{1, 17, 32'h0406E00B};

      bus.en = 1'b0;
      bus.M  = '0;

      // Reset state
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_en_next", bus.en_next, 1'b0);
      chk("rst_w_zero", |bus.W, 1'b0);
`ifdef SHA_SCHED_WIN_IDX_EN
      chk("rst_win_idx", bus.win_idx, 6'd0);
`endif
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // Single "abc" block: cycle-by-cycle busy / en_next timing
      base = npulse;
      do_load(m_abc, l0);
      for (int e = 0; e <= 70; e++) begin
         if (e > 0) @(negedge clk);
         exp_pulse = (e >= DELAY) && (e <= 64) && (e % DELAY == 0);
         chk($sformatf("t1_busy_e%0d", e), bus.busy, (e < 64));
         chk($sformatf("t1_en_next_e%0d", e), bus.en_next, exp_pulse);
      end
      chk("t1_npulse", npulse - base, NWIN);
      check_block("t1", base, 0, m_abc, l0);

      // Back-to-back: en held high, M changed while busy must be ignored
      base = npulse;
      @(negedge clk);
      bus.M  = m_abc;
      bus.en = 1'b1;
      @(negedge clk);
      l0 = cyc;
      for (int e = 1; e <= 140; e++) begin
         @(negedge clk);
         if (e == 5) bus.M = m_cnt;
         if (e == 64) begin
            chk("t2_busy_drop", bus.busy, 1'b0);
            chk("t2_last_pulse", bus.en_next, 1'b1);
         end
         if (e == 65) begin
            chk("t2_reload_busy", bus.busy, 1'b1);
            bus.en = 1'b0;
         end
      end
      chk("t2_npulse", npulse - base, 2*NWIN);
      check_block("t2a", base, 0, m_abc, l0);
      check_block("t2b", base, 1, m_cnt, l0 + 65);

      // Table of hand-computed words against the two captured blocks
      for (int i = 0; i < 12; i++)
         chk($sformatf("vec%0d_blk%0d_w%0d", i, tbl[i].blk, tbl[i].widx),
             cap_word(base, tbl[i].blk, tbl[i].widx), tbl[i].exp);

      // Reset mid-block: immediate clear, no further pulses, clean restart
      do_load(m_abc, l0);
      repeat (19) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t3_async_w_zero", |bus.W, 1'b0);
      chk("t3_async_en_next", bus.en_next, 1'b0);
      chk("t3_async_busy", bus.busy, 1'b0);
`ifdef SHA_SCHED_WIN_IDX_EN
      chk("t3_async_win_idx", bus.win_idx, 6'd0);
`endif
      repeat (3) @(negedge clk);
      reset = 1'b1;
      base = npulse;
      repeat (80) @(negedge clk);
      chk("t3_no_pulses", npulse - base, 0);
      chk("t3_idle_busy", bus.busy, 1'b0);
      base = npulse;
      do_load(m_abc, l0);
      repeat (70) @(negedge clk);
      chk("t3_npulse", npulse - base, NWIN);
      check_block("t3", base, 0, m_abc, l0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
